// File: rtl/mtm_alu_serializer_if.sv
// Bundles the core-to-serializer result pulse, the error report and the serial line.
//
// Handshake: tx_dt_ready and err_valid are single-cycle pulses with no ready
// back-pressure. Payload fields are valid only in the pulse cycle. The serializer
// takes a pulse only while busy=0. A pulse seen while busy=1 is dropped silently.
interface mtm_alu_serializer_if;
  logic        tx_dt_ready;
  logic [31:0] data_C;
  logic [3:0]  data_flag;
  logic [2:0]  data_crc;
  logic        err_valid;
  logic [5:0]  err_flags;
  logic        sout;
  logic        busy;

  modport master (
    output tx_dt_ready, data_C, data_flag, data_crc, err_valid, err_flags,
    input  sout, busy
  );

  modport slave (
    input  tx_dt_ready, data_C, data_flag, data_crc, err_valid, err_flags,
    output sout, busy
  );
endinterface

// File: rtl/mtm_alu_serializer.sv
// Serializes an ALU result (four DATA packets plus one CTL packet) or an error
// report (one CTL packet) onto sout. Each 11-bit packet is sent as start 0,
// type, 8 payload bits MSB first, then stop 1.
module mtm_alu_serializer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mtm_alu_serializer_if.slave  bus,
  output logic [2:0]           state_dbg
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_TYPE  = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [2:0]       bit_idx, bit_n;
  logic [2:0]       pkt_idx, pkt_n;
  logic [2:0]       pkt_last;
  logic             is_err;
  logic [4:0][7:0]  hold;
  logic             capture;
  logic             bit_end;
  logic             sout_n;
  logic             busy_n;
  logic [7:0]       cur_byte;

  assign state_dbg = state;
  assign bit_end   = (div_cnt == DIV_MAX);

  // Next-state logic: every non-idle state lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_idx;
    pkt_n   = pkt_idx;
    capture = 1'b0;
    if (state != S_IDLE) begin
      div_n = bit_end ? '0 : div_cnt + 1'b1;
    end
    case (state)
      S_IDLE: begin
        if (bus.tx_dt_ready || bus.err_valid) begin
          capture = 1'b1;
          state_n = S_START;
          div_n   = '0;
          bit_n   = '0;
          pkt_n   = '0;
        end
      end
      S_START: begin
        if (bit_end) state_n = S_TYPE;
      end
      S_TYPE: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = 3'd7;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd0) state_n = S_STOP;
          else                 bit_n   = bit_idx - 3'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (pkt_idx == pkt_last) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_START;
            pkt_n   = pkt_idx + 3'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Line value for the upcoming cycle, derived from the next state so sout is a flop.
  always_comb begin
    cur_byte = hold[0];
    case (pkt_n)
      3'd1:    cur_byte = hold[1];
      3'd2:    cur_byte = hold[2];
      3'd3:    cur_byte = hold[3];
      3'd4:    cur_byte = hold[4];
      default: cur_byte = hold[0];
    endcase
    busy_n = (state_n != S_IDLE);
    sout_n = 1'b1;
    case (state_n)
      S_START: sout_n = 1'b0;
      S_TYPE:  sout_n = is_err || (pkt_n == 3'd4);
      S_DATA:  sout_n = cur_byte[bit_n];
      default: sout_n = 1'b1;
    endcase
  end

  // State, counters and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      pkt_idx  <= '0;
      bus.sout <= 1'b1;
      bus.busy <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_idx  <= bit_n;
      pkt_idx  <= pkt_n;
      bus.sout <= sout_n;
      bus.busy <= busy_n;
    end
  end

  // Holding registers: the core clears its outputs right after the pulse, so the
  // whole response is latched on the capture edge. An error report wins over a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      pkt_last <= '0;
      is_err   <= 1'b0;
    end else if (capture) begin
      if (bus.err_valid) begin
        hold     <= {32'h0, 1'b1, bus.err_flags, ^{1'b1, bus.err_flags}};
        pkt_last <= 3'd0;
        is_err   <= 1'b1;
      end else begin
        hold     <= {1'b0, bus.data_flag, bus.data_crc,
                     bus.data_C[7:0], bus.data_C[15:8],
                     bus.data_C[23:16], bus.data_C[31:24]};
        pkt_last <= 3'd4;
        is_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: one instance at 1 clock per bit, one at 4.
// Expected packets ({type, payload}) are queued when a pulse is driven and
// popped as the recorded sout trace is decoded.
module tb_mtm_alu_serializer;

  typedef struct packed {
    logic        tx;
    logic        err;
    logic [31:0] c;
    logic [3:0]  fl;
    logic [2:0]  crc;
    logic [5:0]  ef;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst1_n;
  logic       rst4_n;
  logic [2:0] st1;
  logic [2:0] st4;

  mtm_alu_serializer_if bus1 ();
  mtm_alu_serializer_if bus4 ();

  mtm_alu_serializer #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1), .state_dbg(st1)
  );

  mtm_alu_serializer #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .bus(bus4), .state_dbg(st4)
  );

  // Clock
  always #5 clk = ~clk;

  int         n_checks;
  int         n_errors;
  logic [8:0] exp_q[$];
  logic       tr_sout [256];
  logic       tr_busy [256];
  pulse_t     idle_p;
  pulse_t     pa;
  pulse_t     pb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int which, input pulse_t p);
    if (which == 0) begin
      bus1.tx_dt_ready = p.tx;  bus1.err_valid = p.err; bus1.data_C = p.c;
      bus1.data_flag   = p.fl;  bus1.data_crc  = p.crc; bus1.err_flags = p.ef;
    end else begin
      bus4.tx_dt_ready = p.tx;  bus4.err_valid = p.err; bus4.data_C = p.c;
      bus4.data_flag   = p.fl;  bus4.data_crc  = p.crc; bus4.err_flags = p.ef;
    end
  endtask

  // Cycle k of the trace is sampled at the falling edge inside cycle k;
  // the first pulse is driven in cycle 0, an optional second one in cycle p2.
  task automatic record(input int which, input int n, input pulse_t p1, input int p2, input pulse_t q);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0)       drive(which, p1);
      else if (k == p2) drive(which, q);
      else              drive(which, idle_p);
      tr_sout[k] = (which == 0) ? bus1.sout : bus4.sout;
      tr_busy[k] = (which == 0) ? bus1.busy : bus4.busy;
    end
  endtask

  task automatic decode(input int start, input int cpb, input int npkts, input string tag);
    for (int p = 0; p < npkts; p++) begin
      logic [10:0] pk;
      logic [8:0]  e;
      int          hold_bad;
      int          base;
      hold_bad = 0;
      base = start + p * 11 * cpb;
      for (int b = 0; b < 11; b++) begin
        pk[10-b] = tr_sout[base + b*cpb];
        for (int j = 1; j < cpb; j++)
          if (tr_sout[base + b*cpb + j] !== pk[10-b]) hold_bad++;
      end
      check($sformatf("%s_p%0d_start", tag, p), {31'd0, pk[10]}, 32'd0);
      check($sformatf("%s_p%0d_stop", tag, p), {31'd0, pk[0]}, 32'd1);
      if (cpb > 1) check($sformatf("%s_p%0d_hold", tag, p), hold_bad, 0);
      if (exp_q.size() == 0) begin
        check($sformatf("%s_p%0d_unexpected", tag, p), {23'd0, pk[9:1]}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_p%0d_pkt", tag, p), {23'd0, pk[9:1]}, {23'd0, e});
      end
    end
  endtask

  function automatic int count_busy(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(tr_busy[i]);
    return s;
  endfunction

  function automatic int count_low(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(!tr_sout[i]);
    return s;
  endfunction

  function automatic void push_success(input logic [31:0] c, input logic [3:0] fl, input logic [2:0] crc);
    exp_q.push_back({1'b0, c[31:24]});
    exp_q.push_back({1'b0, c[23:16]});
    exp_q.push_back({1'b0, c[15:8]});
    exp_q.push_back({1'b0, c[7:0]});
    exp_q.push_back({1'b1, 1'b0, fl, crc});
  endfunction

  function automatic void push_error(input logic [5:0] ef);
    exp_q.push_back({1'b1, 1'b1, ef, ^{1'b1, ef}});
  endfunction

  initial begin
    logic [10:0] bits;
    n_checks = 0;
    n_errors = 0;
    idle_p   = '0;
    rst1_n   = 1'b0;
    rst4_n   = 1'b0;
    drive(0, idle_p);
    drive(1, idle_p);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sout1", {31'd0, bus1.sout}, 1);
    check("rst_busy1", {31'd0, bus1.busy}, 0);
    check("rst_state1", {29'd0, st1}, 0);
    check("rst_sout4", {31'd0, bus4.sout}, 1);
    check("rst_busy4", {31'd0, bus4.busy}, 0);
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_sout1", {31'd0, bus1.sout}, 1);

    // Success response, 1 clock per bit
    pa = '{tx:1'b1, err:1'b0, c:32'h12345678, fl:4'b0010, crc:3'b101, ef:6'd0};
    exp_q.push_back(9'h012); exp_q.push_back(9'h034); exp_q.push_back(9'h056);
    exp_q.push_back(9'h078); exp_q.push_back(9'h115);
    record(0, 58, pa, -1, idle_p);
    decode(1, 1, 5, "t1");
    check("t1_busy_c0", {31'd0, tr_busy[0]}, 0);
    check("t1_busy_len", count_busy(1, 55), 55);
    check("t1_busy_c56", {31'd0, tr_busy[56]}, 0);
    check("t1_sout_c56", {31'd0, tr_sout[56]}, 1);

    // Error response
    pa = '{tx:1'b0, err:1'b1, c:32'd0, fl:4'd0, crc:3'd0, ef:6'b100100};
    exp_q.push_back(9'h1C9);
    record(0, 14, pa, -1, idle_p);
    for (int i = 0; i < 11; i++) bits[10-i] = tr_sout[1+i];
    check("t2_bits", {21'd0, bits}, {21'd0, 11'b01110010011});
    decode(1, 1, 1, "t2");
    check("t2_busy_len", count_busy(0, 13), 11);
    check("t2_busy_c12", {31'd0, tr_busy[12]}, 0);

    // Result and error together: error wins
    pa = '{tx:1'b1, err:1'b1, c:32'hFFFFFFFF, fl:4'hF, crc:3'h7, ef:6'b010010};
    exp_q.push_back(9'h1A5);
    record(0, 16, pa, -1, idle_p);
    decode(1, 1, 1, "t3");
    check("t3_busy_len", count_busy(0, 15), 11);
    check("t3_no_data", count_low(13, 15), 0);

    // Pulse while busy is ignored
    pa = '{tx:1'b1, err:1'b0, c:32'hCAFEF00D, fl:4'b1001, crc:3'b011, ef:6'd0};
    pb = '{tx:1'b1, err:1'b0, c:32'hDEADBEEF, fl:4'b0101, crc:3'b110, ef:6'd0};
    exp_q.push_back(9'h0CA); exp_q.push_back(9'h0FE); exp_q.push_back(9'h0F0);
    exp_q.push_back(9'h00D); exp_q.push_back(9'h14B);
    record(0, 62, pa, 20, pb);
    decode(1, 1, 5, "t4");
    check("t4_busy_len", count_busy(0, 61), 55);
    check("t4_idle_after", count_low(56, 61), 0);

    // Pulse in the idle cycle right after a response is accepted
    pa = '{tx:1'b1, err:1'b0, c:32'h0F1E2D3C, fl:4'b0100, crc:3'b110, ef:6'd0};
    pb = '{tx:1'b1, err:1'b0, c:32'hA0B0C0D0, fl:4'b1000, crc:3'b001, ef:6'd0};
    exp_q.push_back(9'h00F); exp_q.push_back(9'h01E); exp_q.push_back(9'h02D);
    exp_q.push_back(9'h03C); exp_q.push_back(9'h126);
    exp_q.push_back(9'h0A0); exp_q.push_back(9'h0B0); exp_q.push_back(9'h0C0);
    exp_q.push_back(9'h0D0); exp_q.push_back(9'h141);
    record(0, 115, pa, 56, pb);
    decode(1, 1, 5, "t5a");
    check("t5_busy_c56", {31'd0, tr_busy[56]}, 0);
    check("t5_sout_c56", {31'd0, tr_sout[56]}, 1);
    check("t5_sout_c57", {31'd0, tr_sout[57]}, 0);
    decode(57, 1, 5, "t5b");
    check("t5_busy_len", count_busy(0, 114), 110);

    // Pulse in the last busy cycle is dropped
    pa = '{tx:1'b0, err:1'b1, c:32'd0, fl:4'd0, crc:3'd0, ef:6'b000001};
    pb = '{tx:1'b1, err:1'b0, c:32'h55AA55AA, fl:4'd3, crc:3'd2, ef:6'd0};
    exp_q.push_back(9'h182);
    record(0, 20, pa, 11, pb);
    decode(1, 1, 1, "t6");
    check("t6_busy_len", count_busy(0, 19), 11);
    check("t6_idle_after", count_low(12, 19), 0);

    // Random responses
    for (int r = 0; r < 4; r++) begin
      pa.c   = $urandom;
      pa.fl  = 4'($urandom_range(0, 15));
      pa.crc = 3'($urandom_range(0, 7));
      pa.ef  = 6'($urandom_range(0, 63));
      pa.err = 1'($urandom_range(0, 1));
      pa.tx  = 1'b1;
      if (pa.err) push_error(pa.ef);
      else        push_success(pa.c, pa.fl, pa.crc);
      record(0, 58, pa, -1, idle_p);
      decode(1, 1, pa.err ? 1 : 5, $sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_busy_len", r), count_busy(0, 57), pa.err ? 11 : 55);
    end

    // 4 clocks per bit, full response
    pa = '{tx:1'b1, err:1'b0, c:32'h000000A5, fl:4'd0, crc:3'd0, ef:6'd0};
    exp_q.push_back(9'h000); exp_q.push_back(9'h000); exp_q.push_back(9'h000);
    exp_q.push_back(9'h0A5); exp_q.push_back(9'h100);
    record(1, 224, pa, -1, idle_p);
    decode(1, 4, 5, "t8");
    check("t8_busy_len", count_busy(0, 223), 220);
    check("t8_busy_c220", {31'd0, tr_busy[220]}, 1);
    check("t8_busy_c221", {31'd0, tr_busy[221]}, 0);

    // Asynchronous reset mid-response
    record(1, 30, pa, -1, idle_p);
    @(posedge clk);
    #2;
    check("t9_busy_before", {31'd0, bus4.busy}, 1);
    rst4_n = 1'b0;
    #1;
    check("t9_rst_sout", {31'd0, bus4.sout}, 1);
    check("t9_rst_busy", {31'd0, bus4.busy}, 0);
    check("t9_rst_state", {29'd0, st4}, 0);
    repeat (2) @(negedge clk);
    rst4_n = 1'b1;
    record(1, 20, idle_p, -1, idle_p);
    check("t9_idle_busy", count_busy(0, 19), 0);
    check("t9_idle_sout", count_low(0, 19), 0);

    // Response after reset recovery
    pa = '{tx:1'b0, err:1'b1, c:32'd0, fl:4'd0, crc:3'd0, ef:6'b111111};
    exp_q.push_back(9'h1FF);
    record(1, 48, pa, -1, idle_p);
    decode(1, 4, 1, "t10");
    check("t10_busy_len", count_busy(0, 47), 44);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mtm_alu_serializer.md
# mtm_alu_serializer

Transmit end of the ALU result path. Captures the one-cycle result pulse from `mtm_Alu_core` (`data_C`, `data_flag`, `data_crc`, `tx_dt_ready`) or an error report, and shifts it out on the single serial line `sout` as 11-bit packets. A success response is four DATA packets followed by one CTL packet. An error response is a single CTL packet.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles each serial bit is held on `sout`; legal range ≥1.

- `clk`  in  1  system clock, posedge active
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `tx_dt_ready`  in  1  one-cycle result-valid pulse from core
- `data_C`  in  32  ALU result; valid only while `tx_dt_ready`=1
- `data_flag`  in  4  {carry, overflow, zero, negative}; valid with `tx_dt_ready`
- `data_crc`  in  3  CRC3 of result; valid with `tx_dt_ready`
- `err_valid`  in  1  one-cycle error-report pulse
- `err_flags`  in  6  error flags; valid with `err_valid`
- `sout`  out  1  serial output, idle high
- `busy`  out  1  high while a response is being transmitted

## Operation
- Packet format (11 bits, sent first to last): start `0`, type bit (`0`=DATA, `1`=CTL), 8 payload bits MSB first, stop `1`.
- Success response: DATA `C[31:24]`, DATA `C[23:16]`, DATA `C[15:8]`, DATA `C[7:0]`, then CTL `{1'b0, flag[3:0], crc[2:0]}`. Total 55 bits, no gaps between packets.
- Error response: one CTL packet `{1'b1, err_flags[5:0], p}`. `p` is the even parity of the preceding 7 payload bits: `p = ^{1'b1, err_flags}`.
- Capture: in IDLE with `busy`=0, the block samples `tx_dt_ready`/`err_valid` on a rising edge.
  - On a capture, payload bytes, packet count and response type are registered into internal holding registers. Core outputs are not used after the capture edge; the core zeroes them on the next cycle.
  - If `err_valid` and `tx_dt_ready` are both high in the same cycle, the error wins and the result is discarded.
- While `busy`=1, the block ignores `tx_dt_ready` and `err_valid`. No queueing and no flag are raised.
- FSM:
  - IDLE -> START on capture.
  - START -> TYPE -> DATA (8 bits, bit index 7..0) -> STOP.
  - STOP -> START if packets remain, else -> IDLE.
- Each state holds for `CLKS_PER_BIT` cycles, counted by a divider that reloads at each bit boundary.
- Counters: bit index 3 bits, packet index 0..4, divider sized for `CLKS_PER_BIT`-1. No counter wraps outside its defined range.

## Timing
- Reset (async, `rst_n`=0): `sout`=1, `busy`=0, FSM=IDLE, all counters and holding registers cleared.
  - Reset mid-packet aborts the response immediately and drives `sout` high. After release, the line stays idle until the next capture.
- `sout` and `busy` are registered outputs.
- Capture edge = cycle 0. The start bit appears on `sout` and `busy` rises in cycle 1.
- Bit k of the response occupies cycles `1 + k·CLKS_PER_BIT` through `(k+1)·CLKS_PER_BIT`.
- Success response: `busy` is high for exactly `55·CLKS_PER_BIT` cycles. Error response: exactly `11·CLKS_PER_BIT` cycles.
- In the first cycle after the last stop bit, `busy`=0 and `sout`=1. A pulse in that cycle is captured, so back-to-back responses are separated by one idle-high cycle.
- A pulse arriving in the last `busy`=1 cycle is dropped.

## Test plan
- Reset, then `CLKS_PER_BIT`=1: `tx_dt_ready` pulse with `data_C`=0x12345678, `data_flag`=4'b0010, `data_crc`=3'b101.
  - Required: `sout` carries 55 bits forming packets DATA 0x12, 0x34, 0x56, 0x78, then CTL 0x15.
  - Required: `busy` high for cycles 1..55, and `sout`=1 at cycle 56.
- `err_valid` pulse with `err_flags`=6'b100100 -> a single packet `0,1,1,1,0,0,1,0,0,1,1` (CTL 0xC9). `busy` high for 11 cycles.
- `tx_dt_ready` and `err_valid` high in the same cycle (`data_C`=0xFFFFFFFF, `err_flags`=6'b010010) -> only CTL 0xA5 is sent: `{1,010010}` has three ones, so `p`=1. No DATA packets.
- Second `tx_dt_ready` pulse at cycle 20 of a success response -> ignored; the first response completes unchanged.
- Second pulse at cycle 56 -> accepted, and its start bit appears at cycle 57.
- `CLKS_PER_BIT`=4, `data_C`=0x000000A5 -> every bit is held for 4 cycles and `busy` is high for 220 cycles.
  - Mid-response, `rst_n` is asserted at cycle 30 asynchronously between clock edges. Required: `sout`=1 and `busy`=0 immediately; after release, the line stays idle until the next pulse.
